// File: rtl/mod_event_counter.sv
// Modulo up/down event counter with a wrap flag, a terminal-count pulse and a
// saturating wrap counter. The trig input is asynchronous. It passes through a
// three-flop chain, and one evt is produced per qualifying trig edge.
module mod_event_counter #(
  parameter int MODULUS  = 4,     // count range 0..MODULUS-1 (2..65536)
  parameter int CNT_W    = 2,     // ceil(log2(MODULUS))
  parameter int WRAP_W   = 8,     // width of the saturating wrap counter
  parameter bit EDGE_POL = 1'b0   // 0 = count falling trig edges, 1 = rising
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic              en,
  input  logic              dir,
  input  logic              clr,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_val,
  output logic [CNT_W-1:0]  count,
  output logic              flag,
  output logic              tc_pulse,
  output logic [WRAP_W-1:0] wrap_cnt
);

  // trig rests at this level between events. The sync chain resets to it so
  // that releasing rst cannot look like an edge.
  localparam logic             IDLE_LVL = !EDGE_POL;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MODULUS - 1);

  logic              s1_q, s2_q, s3_q;
  logic              evt;
  logic [CNT_W-1:0]  load_sat;

  logic [CNT_W-1:0]  count_q, count_d;
  logic              flag_q, flag_d;
  logic              tc_q, tc_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              wrapped;

  // Synchronise trig. s1/s2 resolve metastability, and s3 is the delayed copy
  // used for edge detection.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples
  // the values from before the edge and the chain shifts by exactly one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= IDLE_LVL;
      s2_q <= IDLE_LVL;
      s3_q <= IDLE_LVL;
    end else begin
      s1_q <= trig;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // An edge between s3 (older) and s2 (newer) lasts exactly one cycle.
  assign evt = EDGE_POL ? (~s3_q & s2_q) : (s3_q & ~s2_q);

  // Out-of-range load values clamp to the top of the count range.
  assign load_sat = (32'(load_val) >= 32'(MODULUS)) ? MAX_CNT : load_val;

  // Next-state logic. Priority is clr > load > counted event > hold.
  // NOTE: every variable gets a default before any branch. Without the
  // defaults, paths that do not assign a variable would infer latches.
  always_comb begin
    count_d = count_q;
    flag_d  = flag_q;
    wrap_d  = wrap_q;
    tc_d    = 1'b0;
    wrapped = 1'b0;

    if (clr) begin
      count_d = '0;
      flag_d  = 1'b0;
      wrap_d  = '0;
    end else if (load) begin
      count_d = load_sat;
      flag_d  = 1'b0;
    end else if (evt && en) begin
      flag_d = 1'b0;
      if (!dir) begin
        if (count_q == MAX_CNT) begin
          count_d = '0;
          wrapped = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = MAX_CNT;
          wrapped = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end

      if (wrapped) begin
        flag_d = 1'b1;
        tc_d   = 1'b1;
        // Hold at all-ones so a long run never reads as a small wrap count.
        if (wrap_q != '1) begin
          wrap_d = wrap_q + WRAP_W'(1);
        end
      end
    end
  end

  // Counter state registers. rst clears them at once, without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
      tc_q    <= 1'b0;
      wrap_q  <= '0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
      tc_q    <= tc_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count    = count_q;
  assign flag     = flag_q;
  assign tc_pulse = tc_q;
  assign wrap_cnt = wrap_q;

  // The count never leaves 0..MODULUS-1, including for non-power-of-2 moduli.
  a_count_in_range : assert property (
    @(posedge clk) disable iff (rst) count_q <= MAX_CNT
  );

endmodule

// File: tb/tb_mod_event_counter.sv
// Bench for mod_event_counter. Four instances cover the default parameters,
// MODULUS=10, WRAP_W=2 and EDGE_POL=1. Each stimulus pushes its expected
// outputs into a queue with the cycle they are due. A negedge monitor pops
// each entry and compares it against the addressed instance.
module tb_mod_event_counter;

  typedef enum {OP_EVT, OP_CLR, OP_LOAD, OP_EVT_CLR, OP_EVT_LOAD} op_e;

  typedef struct {
    op_e        op;
    int         inst;
    logic       en;
    logic       dir;
    logic [3:0] lv;
    logic [3:0] cnt;
    logic       flag;
    logic       tc;
    logic [7:0] wrap;
  } vec_t;

  typedef struct {
    int         due;
    int         inst;
    logic [3:0] cnt;
    logic       flag;
    logic       tc;
    logic [7:0] wrap;
    string      tag;
  } sb_t;

  logic clk;
  logic rst;
  logic       trig_s [4];
  logic       en_s   [4];
  logic       dir_s  [4];
  logic       clr_s  [4];
  logic       load_s [4];
  logic [3:0] lv_s   [4];

  logic [1:0] cnt0, cnt2, cnt3;
  logic [3:0] cnt1;
  logic       flag0, flag1, flag2, flag3;
  logic       tc0, tc1, tc2, tc3;
  logic [7:0] wrap0, wrap1, wrap3;
  logic [1:0] wrap2;

  int   cyc;
  int   pass_cnt;
  int   total_cnt;
  sb_t  sb [$];
  vec_t tbl [$];

  sb_t        mon_e;
  logic [3:0] mc;
  logic       mf, mt;
  logic [7:0] mw;

  mod_event_counter u_def (
    .clk(clk), .rst(rst), .trig(trig_s[0]), .en(en_s[0]), .dir(dir_s[0]),
    .clr(clr_s[0]), .load(load_s[0]), .load_val(lv_s[0][1:0]),
    .count(cnt0), .flag(flag0), .tc_pulse(tc0), .wrap_cnt(wrap0)
  );

  mod_event_counter #(.MODULUS(10), .CNT_W(4)) u_m10 (
    .clk(clk), .rst(rst), .trig(trig_s[1]), .en(en_s[1]), .dir(dir_s[1]),
    .clr(clr_s[1]), .load(load_s[1]), .load_val(lv_s[1]),
    .count(cnt1), .flag(flag1), .tc_pulse(tc1), .wrap_cnt(wrap1)
  );

  mod_event_counter #(.WRAP_W(2)) u_w2 (
    .clk(clk), .rst(rst), .trig(trig_s[2]), .en(en_s[2]), .dir(dir_s[2]),
    .clr(clr_s[2]), .load(load_s[2]), .load_val(lv_s[2][1:0]),
    .count(cnt2), .flag(flag2), .tc_pulse(tc2), .wrap_cnt(wrap2)
  );

  mod_event_counter #(.EDGE_POL(1'b1)) u_rise (
    .clk(clk), .rst(rst), .trig(trig_s[3]), .en(en_s[3]), .dir(dir_s[3]),
    .clr(clr_s[3]), .load(load_s[3]), .load_val(lv_s[3][1:0]),
    .count(cnt3), .flag(flag3), .tc_pulse(tc3), .wrap_cnt(wrap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp used to schedule scoreboard entries.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic get_out(input int k, output logic [3:0] c, output logic f,
                         output logic t, output logic [7:0] w);
    case (k)
      0:       begin c = {2'b00, cnt0}; f = flag0; t = tc0; w = wrap0; end
      1:       begin c = cnt1;          f = flag1; t = tc1; w = wrap1; end
      2:       begin c = {2'b00, cnt2}; f = flag2; t = tc2; w = {6'd0, wrap2}; end
      default: begin c = {2'b00, cnt3}; f = flag3; t = tc3; w = wrap3; end
    endcase
  endtask

  function automatic vec_t mk(op_e op, int inst, logic en, logic dir, logic [3:0] lv,
                              logic [3:0] cnt, logic flag, logic tc, logic [7:0] wrap);
    vec_t v;
    v.op = op; v.inst = inst; v.en = en; v.dir = dir; v.lv = lv;
    v.cnt = cnt; v.flag = flag; v.tc = tc; v.wrap = wrap;
    return v;
  endfunction

  task automatic push_exp(input int due, input vec_t v, input logic tc, input string tag);
    sb_t e;
    e.due = due; e.inst = v.inst; e.cnt = v.cnt; e.flag = v.flag;
    e.tc = tc; e.wrap = v.wrap; e.tag = tag;
    sb.push_back(e);
  endtask

  // Apply one record. An event is a trig edge driven just after edge n, and
  // its outputs are due at edge n+3. The entry at n+4 checks that tc_pulse has
  // dropped. clr/load land on the next edge.
  task automatic apply(input vec_t v, input string tag);
    int n;
    en_s[v.inst]  = v.en;
    dir_s[v.inst] = v.dir;
    @(posedge clk); #1;
    n = cyc;
    if (v.op == OP_CLR || v.op == OP_LOAD) begin
      if (v.op == OP_CLR) clr_s[v.inst] = 1'b1;
      else begin load_s[v.inst] = 1'b1; lv_s[v.inst] = v.lv; end
      push_exp(n + 1, v, 1'b0, tag);
      push_exp(n + 2, v, 1'b0, {tag, "+1"});
      @(posedge clk); #1;
      clr_s[v.inst] = 1'b0; load_s[v.inst] = 1'b0;
      repeat (3) @(posedge clk);
    end else begin
      trig_s[v.inst] = (v.inst == 3);
      push_exp(n + 3, v, v.tc, tag);
      push_exp(n + 4, v, 1'b0, {tag, "+1"});
      if (v.op != OP_EVT) begin
        // Make clr/load coincide with the edge where evt is consumed.
        repeat (2) @(posedge clk); #1;
        if (v.op == OP_EVT_CLR) clr_s[v.inst] = 1'b1;
        else begin load_s[v.inst] = 1'b1; lv_s[v.inst] = v.lv; end
        @(posedge clk); #1;
        clr_s[v.inst] = 1'b0; load_s[v.inst] = 1'b0;
      end
      repeat (5) @(posedge clk); #1;
      // The return edge has the opposite polarity and must not count.
      trig_s[v.inst] = (v.inst != 3);
      repeat (5) @(posedge clk);
    end
  endtask

  // Scoreboard monitor. Samples on the falling edge, away from updates.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.due != cyc) begin
        check($sformatf("%s late", mon_e.tag), 32'(cyc), 32'(mon_e.due));
      end else begin
        get_out(mon_e.inst, mc, mf, mt, mw);
        check($sformatf("%s count", mon_e.tag), 32'(mc), 32'(mon_e.cnt));
        check($sformatf("%s flag",  mon_e.tag), 32'(mf), 32'(mon_e.flag));
        check($sformatf("%s tc",    mon_e.tag), 32'(mt), 32'(mon_e.tc));
        check($sformatf("%s wrap",  mon_e.tag), 32'(mw), 32'(mon_e.wrap));
      end
    end
  end

  initial begin
    logic [3:0] c;
    logic       f, t;
    logic [7:0] w;
    int         wr;

    cyc = 0; pass_cnt = 0; total_cnt = 0;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      trig_s[k] = (k != 3); en_s[k] = 1'b0; dir_s[k] = 1'b0;
      clr_s[k] = 1'b0; load_s[k] = 1'b0; lv_s[k] = 4'd0;
    end

    // Table: op, inst, en, dir, load_val -> count, flag, tc, wrap
    tbl.push_back(mk(OP_EVT,      0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(OP_EVT,      0, 1'b1, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(OP_EVT,      0, 1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(OP_EVT,      0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 8'd1));
    tbl.push_back(mk(OP_EVT,      0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 8'd1));
    tbl.push_back(mk(OP_EVT,      0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 8'd1));
    tbl.push_back(mk(OP_EVT,      0, 1'b1, 1'b1, 4'd0, 4'd3, 1'b1, 1'b1, 8'd2));
    tbl.push_back(mk(OP_EVT,      0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 8'd3));
    tbl.push_back(mk(OP_EVT,      0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 8'd3));
    tbl.push_back(mk(OP_LOAD,     0, 1'b1, 1'b0, 4'd2, 4'd2, 1'b0, 1'b0, 8'd3));
    tbl.push_back(mk(OP_EVT_CLR,  0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(OP_LOAD,     0, 1'b1, 1'b0, 4'd3, 4'd3, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(OP_EVT,      0, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(OP_EVT,      0, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(OP_EVT,      0, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(OP_EVT_LOAD, 0, 1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(OP_EVT,      3, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(OP_EVT,      3, 1'b1, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, 8'd0));

    // Reset state, observed while rst is held.
    repeat (3) @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      get_out(k, c, f, t, w);
      check($sformatf("reset%0d count", k), 32'(c), 32'd0);
      check($sformatf("reset%0d flag", k),  32'(f), 32'd0);
      check($sformatf("reset%0d tc", k),    32'(t), 32'd0);
      check($sformatf("reset%0d wrap", k),  32'(w), 32'd0);
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // MODULUS=10 counting down from reset: a wrap to 9, then nine steps to 0.
    apply(mk(OP_EVT, 1, 1'b1, 1'b1, 4'd0, 4'd9, 1'b1, 1'b1, 8'd1), "m10_dn0");
    for (int i = 1; i <= 9; i++)
      apply(mk(OP_EVT, 1, 1'b1, 1'b1, 4'd0, 4'(9 - i), 1'b0, 1'b0, 8'd1),
            $sformatf("m10_dn%0d", i));
    // Out-of-range loads clamp to 9. The next up event then wraps.
    apply(mk(OP_LOAD, 1, 1'b1, 1'b0, 4'd12, 4'd9, 1'b0, 1'b0, 8'd1), "m10_ld12");
    apply(mk(OP_EVT,  1, 1'b1, 1'b0, 4'd0,  4'd0, 1'b1, 1'b1, 8'd2), "m10_upwrap");
    apply(mk(OP_LOAD, 1, 1'b1, 1'b0, 4'd10, 4'd9, 1'b0, 1'b0, 8'd2), "m10_ld10");
    apply(mk(OP_LOAD, 1, 1'b1, 1'b0, 4'd5,  4'd5, 1'b0, 1'b0, 8'd2), "m10_ld5");

    // WRAP_W=2: five full wraps. wrap_cnt sticks at 3 and tc still pulses.
    for (int i = 1; i <= 20; i++) begin
      wr = (i / 4 > 3) ? 3 : i / 4;
      apply(mk(OP_EVT, 2, 1'b1, 1'b0, 4'd0, 4'(i % 4), (i % 4 == 0), (i % 4 == 0), 8'(wr)),
            $sformatf("w2_ev%0d", i));
    end

    // Reset while an event is in the sync chain. The clear is asynchronous and
    // the event is lost.
    @(posedge clk); #1;
    trig_s[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      get_out(k, c, f, t, w);
      check($sformatf("async_rst%0d count", k), 32'(c), 32'd0);
      check($sformatf("async_rst%0d wrap", k),  32'(w), 32'd0);
    end
    trig_s[0] = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk); #1;
    get_out(0, c, f, t, w);
    check("rst_drop count", 32'(c), 32'd0);
    check("rst_drop flag",  32'(f), 32'd0);
    apply(mk(OP_EVT, 0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 8'd0), "post_rst");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) check("sb_drain", 32'(sb.size()), 32'd0);
    @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
